// File: rtl/sys_ctrl.sv
// sys_ctrl: serialises one system request (CSR access, trap, xRET) at a time.
// The sequence is accept -> drain older instructions -> one-cycle CSR issue ->
// one-cycle response (writeback + redirect). Issue stays stalled throughout.
module sys_ctrl #(
   parameter int unsigned DRAIN_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   // request from execute
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_pc,
   input  logic [4:0]  req_op,
   input  logic [11:0] req_csr,
   input  logic [63:0] req_tval,
   input  logic [63:0] req_wdata,
   input  logic [4:0]  req_rd,
   input  logic        pipe_busy,
   // CSR file interface
   output logic [63:0] csr_pc,
   output logic [4:0]  csr_op,
   output logic [63:0] csr_tval,
   output logic [63:0] csr_wdata,
   input  logic [63:0] csr_rdata,
   input  logic        csr_r_valid,
   input  logic        csr_invalid,
   input  logic        csr_trap_en,
   input  logic [63:0] csr_trap_pc,
   // pipeline control
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        redir_valid,
   output logic [63:0] redir_pc,
   output logic        hang_err
);

   // SYSOP codes shared with the CSR file; bit 4 flags an exception.
   localparam logic [4:0] SYSOP_CSR_W = 5'h01;
   localparam logic [4:0] SYSOP_CSR_S = 5'h02;
   localparam logic [4:0] SYSOP_CSR_C = 5'h03;

   localparam int unsigned CntW   = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DRAIN_TIMEOUT);

   if (DRAIN_TIMEOUT < 1) begin : gen_bad_timeout
      $error("sys_ctrl: DRAIN_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StIssue,
      StResp
   } state_e;

   state_e state_q, state_d;

   // request fields captured at acceptance; req_* may change afterwards
   logic [63:0] pc_q;
   logic [4:0]  op_q;
   logic [11:0] csr_q;
   logic [63:0] tval_q;
   logic [63:0] wdata_q;
   logic [4:0]  rd_q;

   // drain watchdog
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            hang_q, hang_d;

   // CSR-side operand registers; they hold their value outside ISSUE
   logic [63:0] csr_pc_q;
   logic [63:0] csr_tval_q;
   logic [63:0] csr_wdata_q;

   // CSR response captured at the end of ISSUE
   logic [63:0] rdata_q;
   logic        r_valid_q;
   logic        invalid_q;
   logic        trap_en_q;
   logic [63:0] trap_pc_q;

   logic accept;
   logic issue_load;
   logic is_csr_op;

   assign accept     = (state_q == StIdle) && req_valid;
   assign issue_load = (state_q == StDrain) && !pipe_busy;
   assign is_csr_op  = (op_q == SYSOP_CSR_W) || (op_q == SYSOP_CSR_S) || (op_q == SYSOP_CSR_C);

   // State, watchdog and sticky hang flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hang_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hang_q  <= hang_d;
      end
   end

   // Capture the request when it is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         op_q    <= '0;
         csr_q   <= '0;
         tval_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
      end else if (accept) begin
         pc_q    <= req_pc;
         op_q    <= req_op;
         csr_q   <= req_csr;
         tval_q  <= req_tval;
         wdata_q <= req_wdata;
         rd_q    <= req_rd;
      end
   end

   // Load CSR operands on entry to ISSUE so they are valid for that whole cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_pc_q    <= '0;
         csr_tval_q  <= '0;
         csr_wdata_q <= '0;
      end else if (issue_load) begin
         csr_pc_q    <= pc_q;
         // CSR ops carry the CSR address on the tval lane
         csr_tval_q  <= is_csr_op ? {52'b0, csr_q} : tval_q;
         csr_wdata_q <= wdata_q;
      end
   end

   // Sample the CSR file's answer at the end of the single ISSUE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q   <= '0;
         r_valid_q <= 1'b0;
         invalid_q <= 1'b0;
         trap_en_q <= 1'b0;
         trap_pc_q <= '0;
      end else if (state_q == StIssue) begin
         rdata_q   <= csr_rdata;
         r_valid_q <= csr_r_valid;
         invalid_q <= csr_invalid;
         trap_en_q <= csr_trap_en;
         trap_pc_q <= csr_trap_pc;
      end
   end

   // Next-state, drain watchdog and sequence outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hang_d      = hang_q;
      req_ready   = 1'b0;
      busy        = 1'b1;
      csr_op      = '0;
      wb_valid    = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
      redir_valid = 1'b0;
      redir_pc    = '0;

      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            cnt_d     = '0;
            if (req_valid) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!pipe_busy) begin
               state_d = StIssue;
               cnt_d   = '0;
            end else begin
               // count only cycles spent still waiting; saturate at the limit
               if (cnt_q != CntMax) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (cnt_d == CntMax) begin
                  hang_d = 1'b1;
               end
            end
         end
         StIssue: begin
            csr_op  = op_q;
            state_d = StResp;
         end
         StResp: begin
            redir_valid = 1'b1;
            redir_pc    = trap_en_q ? trap_pc_q : pc_q + 64'd4;
            wb_valid    = r_valid_q & ~invalid_q & (rd_q != 5'd0);
            wb_rd       = rd_q;
            wb_data     = rdata_q;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign csr_pc    = csr_pc_q;
   assign csr_tval  = csr_tval_q;
   assign csr_wdata = csr_wdata_q;
   assign hang_err  = hang_q;

endmodule
